divider_arbiter: RTL and testbench
==================================

// Module: divider_arbiter
// PURPOSE
//   Shares one sequential divider (start/done handshake, W-bit operands) among NREQ requesters.
//   Arbitrates round-robin, latches operands, pulses start, waits for done, returns the result tagged with the requester id.
//   Short-circuits divide-by-zero without using the divider and enforces a completion timeout.
//   Sits between requesting datapath blocks and the single shared divider instance.
// PARAMETERS
//   NREQ     4    number of requesters (2..8); IDW = $clog2(NREQ)
//   W        4    operand/result width; must match the divider
//   TIMEOUT  16   max cycles in WAIT before error (>= divider latency + 2)
// PORTS
//   clk           in   1        clock, rising edge
//   rst           in   1        asynchronous, active-high reset
//   req_valid     in   NREQ     per-requester request valid; held until its req_ready
//   req_ready     out  NREQ     one-hot grant/accept, combinational, IDLE only
//   req_dividend  in   NREQ*W   packed dividends; requester i at [i*W +: W]
//   req_divisor   in   NREQ*W   packed divisors; same packing
//   rsp_valid     out  1        response valid; held until rsp_ready
//   rsp_ready     in   1        response accept
//   rsp_id        out  IDW      requester index of the response
//   rsp_quotient  out  W        quotient
//   rsp_remainder out  W        remainder
//   rsp_dbz       out  1        divide-by-zero flag
//   rsp_err       out  1        timeout flag
//   div_start     out  1        one-cycle start pulse to the divider
//   div_dividend  out  W        operand to the divider, stable from ISSUE until done
//   div_divisor   out  W        operand to the divider, stable from ISSUE until done
//   div_done      in   1        divider done (level; cleared by the divider on start)
//   div_quotient  in   W        divider quotient, valid while div_done=1
//   div_remainder in   W        divider remainder, valid while div_done=1
//   busy          out  1        1 in any state other than IDLE
// BEHAVIOUR
//   Reset: state=IDLE, rr pointer=0, every output 0, all latched operands/results 0.
//   FSM:
//   - IDLE: if any req_valid, g = first valid index at/after pointer (wrapping); req_ready[g]=1 in this cycle.
//     Latch dividend, divisor and g.
//     Next state is ISSUE, or RESP with dbz=1 if the divisor is 0.
//   - ISSUE: div_start=1 for exactly one cycle; clear the timeout counter; go to WAIT.
//   - WAIT: counter increments every cycle.
//     div_done is ignored on the first WAIT cycle (stale done from the previous op).
//     From the second WAIT cycle, div_done=1 latches quotient/remainder and goes to RESP.
//     If the counter reaches TIMEOUT-1 with no done: go to RESP with err=1, quotient=0, remainder=0.
//   - RESP: rsp_valid=1; outputs are registered and stable.
//     On rsp_valid & rsp_ready: go to IDLE, pointer=(g+1) mod NREQ.
//     No new grant is issued in that same cycle.
//   Divide-by-zero: quotient = all-ones, remainder = dividend, rsp_dbz=1; div_start is never pulsed.
//   Latency, request accept to rsp_valid:
//   - normal: 2 + divider cycles;
//   - dbz: 1 cycle;
//   - timeout: TIMEOUT+1 cycles.
//   req_ready is 0 in all states except IDLE, so at most one operation is in flight.
//   A requester dropping req_valid before its grant is simply skipped.
//   The pointer advances only on response completion, which gives starvation freedom.
//   rsp_dbz and rsp_err are never both 1; both are 0 for a normal result.
//   Reset mid-operation: immediate return to IDLE with all outputs 0.
//   The in-flight request is lost and the divider is left to finish unobserved.
//   The first post-reset WAIT ignores its stale done by the rule above.
// TESTING
//   1. Reset: all outputs 0, busy=0 -> assert and release rst; every port reads 0, pointer=0.
//   2. Basic: req_valid=0001, 13/3 with a 4-step divider model
//      -> one div_start pulse; rsp_id=0, q=4, r=1, dbz=0, err=0.
//   3. Div-by-zero: requester 2 sends 9/0
//      -> rsp_valid on the cycle after accept; q=F, r=9, dbz=1; div_start stays 0.
//   4. Fairness: req_valid=1111 held, each op 15/2
//      -> grants 0,1,2,3,0 in that order; every response q=7, r=1.
//   5. Backpressure/timeout: rsp_ready=0 for 5 cycles -> rsp_* held stable, req_ready=0;
//      div_done tied 0 -> err=1, q=0, r=0 exactly TIMEOUT cycles after ISSUE.
//   6. Reset mid-WAIT: rst pulsed during WAIT -> IDLE and outputs 0 at once;
//      the next request 7/2 returns q=3, r=1 correctly.

Source files
------------

// File: rtl/divider_arbiter.sv
// Round-robin front end sharing one sequential divider among NREQ requesters.
// Ports: req_* in/ready, rsp_* out/ready, div_* to the shared divider, busy.
module divider_arbiter #(
  parameter int NREQ    = 4,
  parameter int W       = 4,
  parameter int TIMEOUT = 16,
  localparam int IDW    = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_dividend,
  input  logic [NREQ*W-1:0] req_divisor,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_quotient,
  output logic [W-1:0]      rsp_remainder,
  output logic              rsp_dbz,
  output logic              rsp_err,
  output logic              div_start,
  output logic [W-1:0]      div_dividend,
  output logic [W-1:0]      div_divisor,
  input  logic              div_done,
  input  logic [W-1:0]      div_quotient,
  input  logic [W-1:0]      div_remainder,
  output logic              busy
);

  localparam int CW = $clog2(TIMEOUT + 1);
  // Leaving WAIT when the count is TIMEOUT-2 means the
  // counter reaches TIMEOUT-1 on the same edge.
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [IDW-1:0]  ptr;
  logic [CW-1:0]   cnt;
  logic            gnt_found;
  logic [IDW-1:0]  gnt_id;
  logic [W-1:0]    sel_a;
  logic [W-1:0]    sel_b;
  logic [IDW:0]    scan;
  logic            done_ok;
  logic [IDW-1:0]  ptr_nxt;

  // Rotating priority search starting at ptr.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    scan      = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan = {1'b0, ptr} + (IDW+1)'(k);
      if (scan >= (IDW+1)'(NREQ))
        scan = scan - (IDW+1)'(NREQ);
      if (!gnt_found && req_valid[scan[IDW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_id    = scan[IDW-1:0];
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_id == IDW'(i)) begin
        sel_a = req_dividend[i*W +: W];
        sel_b = req_divisor[i*W +: W];
      end
    end
  end

  // The first WAIT cycle may still see done from the previous op.
  assign done_ok = (cnt != '0) && div_done;

  assign ptr_nxt = (rsp_id == IDW'(NREQ - 1)) ?
                   '0 : rsp_id + IDW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (gnt_found)
          state_nxt = (sel_b == '0) ? S_RESP : S_ISSUE;
      end
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT: begin
        if (done_ok || cnt == TLAST)
          state_nxt = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    div_start = 1'b0;
    rsp_valid = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        for (int i = 0; i < NREQ; i++)
          req_ready[i] = gnt_found && (gnt_id == IDW'(i));
      end
      S_ISSUE: div_start = 1'b1;
      S_RESP:  rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr           <= '0;
      cnt           <= '0;
      div_dividend  <= '0;
      div_divisor   <= '0;
      rsp_id        <= '0;
      rsp_quotient  <= '0;
      rsp_remainder <= '0;
      rsp_dbz       <= 1'b0;
      rsp_err       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (gnt_found) begin
            div_dividend <= sel_a;
            div_divisor  <= sel_b;
            rsp_id       <= gnt_id;
            rsp_err      <= 1'b0;
            if (sel_b == '0) begin
              rsp_quotient  <= '1;
              rsp_remainder <= sel_a;
              rsp_dbz       <= 1'b1;
            end else begin
              rsp_quotient  <= '0;
              rsp_remainder <= '0;
              rsp_dbz       <= 1'b0;
            end
          end
        end
        S_ISSUE: cnt <= '0;
        S_WAIT: begin
          cnt <= cnt + CW'(1);
          if (done_ok) begin
            rsp_quotient  <= div_quotient;
            rsp_remainder <= div_remainder;
          end else if (cnt == TLAST) begin
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
            rsp_err       <= 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) ptr <= ptr_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_arbiter.sv
// Directed bench for divider_arbiter with a small sequential divider model.
// Covers reset, basic op, divide-by-zero, fairness, timeout, mid-op reset.
module tb_divider_arbiter;

  localparam int NREQ    = 4;
  localparam int W       = 4;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [15:0] req_dividend;
  logic [15:0] req_divisor;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [3:0]  rsp_quotient;
  logic [3:0]  rsp_remainder;
  logic        rsp_dbz;
  logic        rsp_err;
  logic        div_start;
  logic [3:0]  div_dividend;
  logic [3:0]  div_divisor;
  logic        div_done;
  logic [3:0]  div_quotient;
  logic [3:0]  div_remainder;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int n_start  = 0;
  logic        div_hang = 1'b0;
  int          m_cnt = 0;
  logic [3:0]  m_a, m_b;

  divider_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_quotient(rsp_quotient),
    .rsp_remainder(rsp_remainder), .rsp_dbz(rsp_dbz),
    .rsp_err(rsp_err), .div_start(div_start),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_done(div_done), .div_quotient(div_quotient),
    .div_remainder(div_remainder), .busy(busy)
  );

  always #5 clk = ~clk;

  // 4-step divider model: start clears done, result appears later.
  always @(posedge clk) begin
    if (div_start) begin
      n_start  <= n_start + 1;
      m_a      <= div_dividend;
      m_b      <= div_divisor;
      m_cnt    <= 4;
      div_done <= 1'b0;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1 && !div_hang) begin
        div_done      <= 1'b1;
        div_quotient  <= m_a / m_b;
        div_remainder <= m_a % m_b;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int id, input logic [3:0] a,
                           input logic [3:0] b);
    req_valid = '0;
    req_valid[id] = 1'b1;
    req_dividend[id*4 +: 4] = a;
    req_divisor[id*4 +: 4]  = b;
  endtask

  task automatic wait_rsp(input int maxc, output int cyc);
    cyc = 0;
    while (!rsp_valid && cyc < maxc) begin
      step();
      cyc++;
    end
  endtask

  task automatic complete();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '0;
    req_dividend = '0;
    req_divisor = '0;
    rsp_ready = 1'b0;
    div_done = 1'b0;
    div_quotient = '0;
    div_remainder = '0;
    step();
    step();
    rst = 1'b0;
    step();
    n_checks++;
    if ({rsp_valid, rsp_id, rsp_quotient, rsp_remainder} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_rsp got %h want 0",
               {rsp_valid, rsp_id, rsp_quotient, rsp_remainder});
    end
    n_checks++;
    if ({rsp_dbz, rsp_err, div_start, busy, req_ready} !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_ctl got %h want 0",
               {rsp_dbz, rsp_err, div_start, busy, req_ready});
    end
    n_checks++;
    if ({div_dividend, div_divisor} !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_ops got %h want 0", {div_dividend, div_divisor});
    end
  endtask

  task automatic test_basic();
    int cyc;
    int s0;
    s0 = n_start;
    drive_req(0, 4'd13, 4'd3);
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL basic_ready got %b want 0001", req_ready);
    end
    step();
    req_valid = '0;
    n_checks++;
    if (div_start !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_issue got start=%b busy=%b want 1 1",
               div_start, busy);
    end
    wait_rsp(40, cyc);
    n_checks++;
    if (rsp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_rsp_timeout got %b want 1", rsp_valid);
    end
    n_checks++;
    if ({rsp_id, rsp_quotient, rsp_remainder, rsp_dbz, rsp_err}
        !== {2'd0, 4'd4, 4'd1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_result got id=%0d q=%h r=%h dbz=%b err=%b want 0 4 1 0 0",
               rsp_id, rsp_quotient, rsp_remainder, rsp_dbz, rsp_err);
    end
    n_checks++;
    if (n_start - s0 !== 1) begin
      n_fail++;
      $display("FAIL basic_starts got %0d want 1", n_start - s0);
    end
    complete();
    n_checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_idle got busy=%b valid=%b want 0 0",
               busy, rsp_valid);
    end
  endtask

  task automatic test_dbz();
    int s0;
    s0 = n_start;
    drive_req(2, 4'd9, 4'd0);
    #1;
    n_checks++;
    if (req_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL dbz_ready got %b want 0100", req_ready);
    end
    step();
    req_valid = '0;
    n_checks++;
    if (rsp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL dbz_latency got valid=%b want 1", rsp_valid);
    end
    n_checks++;
    if ({rsp_id, rsp_quotient, rsp_remainder, rsp_dbz, rsp_err}
        !== {2'd2, 4'hF, 4'd9, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL dbz_result got id=%0d q=%h r=%h dbz=%b err=%b want 2 F 9 1 0",
               rsp_id, rsp_quotient, rsp_remainder, rsp_dbz, rsp_err);
    end
    step();
    step();
    n_checks++;
    if (n_start !== s0 || rsp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL dbz_nostart got starts=%0d valid=%b want 0 1",
               n_start - s0, rsp_valid);
    end
    complete();
  endtask

  task automatic test_fairness();
    int cyc;
    logic [3:0] exp_g;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    req_valid    = 4'b1111;
    req_dividend = {4{4'd15}};
    req_divisor  = {4{4'd2}};
    for (int k = 0; k < 5; k++) begin
      #1;
      exp_g = 4'b0001 << (k % 4);
      n_checks++;
      if (req_ready !== exp_g) begin
        n_fail++;
        $display("FAIL fair_grant%0d got %b want %b", k, req_ready, exp_g);
      end
      step();
      wait_rsp(40, cyc);
      n_checks++;
      if (rsp_valid !== 1'b1 || req_ready !== 4'b0000) begin
        n_fail++;
        $display("FAIL fair_rsp%0d got valid=%b ready=%b want 1 0000",
                 k, rsp_valid, req_ready);
      end
      n_checks++;
      if ({rsp_id, rsp_quotient, rsp_remainder, rsp_err, rsp_dbz}
          !== {2'(k % 4), 4'd7, 4'd1, 2'b00}) begin
        n_fail++;
        $display("FAIL fair_result%0d got id=%0d q=%h r=%h want %0d 7 1",
                 k, rsp_id, rsp_quotient, rsp_remainder, k % 4);
      end
      complete();
    end
    req_valid = '0;
  endtask

  task automatic test_timeout();
    int cyc;
    logic [10:0] snap;
    div_hang = 1'b1;
    drive_req(1, 4'd8, 4'd2);
    step();
    req_valid = '0;
    n_checks++;
    if (div_start !== 1'b1) begin
      n_fail++;
      $display("FAIL to_issue got %b want 1", div_start);
    end
    wait_rsp(40, cyc);
    n_checks++;
    if (rsp_valid !== 1'b1 || cyc !== TIMEOUT) begin
      n_fail++;
      $display("FAIL to_latency got valid=%b cycles=%0d want 1 %0d",
               rsp_valid, cyc, TIMEOUT);
    end
    n_checks++;
    if ({rsp_id, rsp_quotient, rsp_remainder, rsp_dbz, rsp_err}
        !== {2'd1, 4'd0, 4'd0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL to_result got id=%0d q=%h r=%h dbz=%b err=%b want 1 0 0 0 1",
               rsp_id, rsp_quotient, rsp_remainder, rsp_dbz, rsp_err);
    end
    snap = {rsp_valid, rsp_id, rsp_quotient, rsp_remainder};
    req_valid = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      step();
      n_checks++;
      if ({rsp_valid, rsp_id, rsp_quotient, rsp_remainder} !== snap ||
          rsp_err !== 1'b1 || req_ready !== 4'b0000) begin
        n_fail++;
        $display("FAIL to_hold%0d got %h err=%b ready=%b want %h 1 0000",
                 k, {rsp_valid, rsp_id, rsp_quotient, rsp_remainder},
                 rsp_err, req_ready, snap);
      end
    end
    complete();
    req_valid = '0;
    div_hang = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    int cyc;
    drive_req(3, 4'd12, 4'd5);
    step();
    req_valid = '0;
    step();
    step();
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_inwait got busy=%b want 1", busy);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, rsp_valid, div_start, div_dividend, div_divisor,
         rsp_quotient, rsp_remainder, rsp_id} !== 22'd0) begin
      n_fail++;
      $display("FAIL rmid_clear got %h want 0",
               {busy, rsp_valid, div_start, div_dividend, div_divisor,
                rsp_quotient, rsp_remainder, rsp_id});
    end
    step();
    rst = 1'b0;
    step();
    drive_req(0, 4'd7, 4'd2);
    step();
    req_valid = '0;
    wait_rsp(40, cyc);
    n_checks++;
    if ({rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_dbz, rsp_err}
        !== {1'b1, 2'd0, 4'd3, 4'd1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL rmid_result got v=%b id=%0d q=%h r=%h err=%b want 1 0 3 1 0",
               rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_err);
    end
    complete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_dbz();
    test_fairness();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
